nibble_packer: RTL and testbench

Upstream stage that assembles narrow IN_WIDTH-bit beats into WIDTH-bit words for param_module's data_in.
- Buffers completed words in a DEPTH-entry FIFO.
- Valid/ready handshake on both sides.
- Short packets (in_last before a full word) are padded with INIT_VAL bits and flagged partial.

---
 rtl/nibble_packer_pkg.sv | 29 ++
 rtl/nibble_packer_if.sv | 32 +++
 rtl/nibble_packer_sync_fifo.sv | 61 ++++++
 rtl/nibble_packer.sv | 120 ++++++++++++
 tb/tb_nibble_packer.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/nibble_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : packer_pkg
// Brief    : Shared types and helpers for the nibble packer.
// Revision : 1.0 - initial release
// ============================================================================
package packer_pkg;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FILL  = 1'b1
    } state_t;

    localparam int MAX_WIDTH = 1024;

    // Legal when beats tile the word exactly and at least two beats are needed.
    function automatic bit ratio_ok(input int width, input int in_width);
        return (in_width > 0) && (width % in_width == 0) && (width / in_width >= 2);
    endfunction

    // Ones over the slot that beat number beat_idx occupies in the word.
    function automatic logic [MAX_WIDTH-1:0] slot_mask(input int beat_idx, input int in_width);
        logic [MAX_WIDTH-1:0] ones;
        ones = (MAX_WIDTH'(1) << in_width) - MAX_WIDTH'(1);
        return ones << (beat_idx * in_width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : nibble_packer_if
// Brief    : Beat input and word output handshake bundle for nibble_packer.
// Revision : 1.0 - initial release
// ============================================================================
interface nibble_packer_if #(
    parameter int WIDTH    = 8,
    parameter int IN_WIDTH = 4,
    parameter int DEPTH    = 4
);
    logic                       in_valid;
    logic                       in_ready;
    logic [IN_WIDTH-1:0]        in_data;
    logic                       in_last;
    logic                       out_valid;
    logic                       out_ready;
    logic [WIDTH-1:0]           out_data;
    logic                       out_partial;
    logic [$clog2(DEPTH+1)-1:0] count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_partial, count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_partial, count
    );
endinterface
`default_nettype wire

// File: rtl/nibble_packer_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with registered head; any DEPTH >= 2.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    input  wire logic                       push,
    input  wire logic [WIDTH-1:0]           push_data,
    input  wire logic                       pop,
    output logic      [WIDTH-1:0]           pop_data,
    output logic      [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && (count != CNT_W'(DEPTH));
    assign do_pop   = pop  && (count != '0);
    assign pop_data = mem[rd_ptr];

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH-1)) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/nibble_packer.sv
`default_nettype none
// ============================================================================
// Module   : nibble_packer
// Brief    : Packs IN_WIDTH-bit beats little-endian into WIDTH-bit words, FIFO out.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_packer
    import packer_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               IN_WIDTH = 4,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] INIT_VAL = 8'hFF
) (
    input wire logic       clk,
    input wire logic       reset,
    nibble_packer_if.slave bus
);
    localparam int RATIO = WIDTH / IN_WIDTH;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    generate
        if (!ratio_ok(WIDTH, IN_WIDTH)) begin : g_bad_ratio
            $error("nibble_packer: WIDTH must be a multiple of IN_WIDTH with WIDTH/IN_WIDTH >= 2");
        end
        if (DEPTH < 2) begin : g_bad_depth
            $error("nibble_packer: DEPTH must be >= 2");
        end
    endgenerate

    state_t               state;
    state_t               state_next;
    logic [IDX_W-1:0]     beat_idx;
    logic [WIDTH-1:0]     acc;
    logic [CNT_W-1:0]     count;
    logic                 accept;
    logic                 is_final;
    logic                 push;
    logic                 partial;
    logic [MAX_WIDTH-1:0] mask_wide;
    logic [WIDTH-1:0]     mask;
    logic [WIDTH-1:0]     beat_shifted;
    logic [WIDTH-1:0]     merged;
    logic [WIDTH:0]       head;

    // in_ready looks only at stored occupancy, never at out_ready.
    assign bus.in_ready = !reset && (count != CNT_W'(DEPTH));
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_final     = (beat_idx == IDX_W'(RATIO-1)) || bus.in_last;

    assign mask_wide    = slot_mask(int'(beat_idx), IN_WIDTH);
    assign mask         = mask_wide[WIDTH-1:0];
    assign beat_shifted = {{(WIDTH-IN_WIDTH){1'b0}}, bus.in_data} << (int'(beat_idx) * IN_WIDTH);
    assign merged       = (acc & ~mask) | (beat_shifted & mask);

    always_comb begin
        state_next = state;
        push       = 1'b0;
        partial    = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    if (is_final) begin
                        push    = 1'b1;
                        partial = bus.in_last && (beat_idx != IDX_W'(RATIO-1));
                    end else begin
                        state_next = FILL;
                    end
                end
            end
            FILL: begin
                if (accept && is_final) begin
                    push       = 1'b1;
                    partial    = bus.in_last && (beat_idx != IDX_W'(RATIO-1));
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            beat_idx <= '0;
            acc      <= INIT_VAL;
        end else begin
            state <= state_next;
            if (accept) begin
                if (is_final) begin
                    beat_idx <= '0;
                    acc      <= INIT_VAL;
                end else begin
                    beat_idx <= beat_idx + 1'b1;
                    acc      <= merged;
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({partial, merged}),
        .pop       (bus.out_valid && bus.out_ready),
        .pop_data  (head),
        .count     (count)
    );

    assign bus.out_valid   = (count != '0);
    assign bus.out_data    = head[WIDTH-1:0];
    assign bus.out_partial = head[WIDTH];
    assign bus.count       = count;
endmodule
`default_nettype wire

// File: tb/tb_nibble_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_packer
// Brief    : Randomized and directed bench for nibble_packer with a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_packer;
    localparam int         WIDTH    = 8;
    localparam int         IN_WIDTH = 4;
    localparam int         DEPTH    = 4;
    localparam logic [7:0] INIT_VAL = 8'hFF;
    localparam int         RATIO    = WIDTH / IN_WIDTH;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_words = 0;

    logic [8:0] q[$];
    logic [3:0] beats[$];

    always #5 clk = ~clk;

    nibble_packer_if #(.WIDTH(WIDTH), .IN_WIDTH(IN_WIDTH), .DEPTH(DEPTH)) bus_if ();

    nibble_packer #(
        .WIDTH    (WIDTH),
        .IN_WIDTH (IN_WIDTH),
        .DEPTH    (DEPTH),
        .INIT_VAL (INIT_VAL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        check("count", 32'(bus_if.count), 32'(q.size()));
        check("out_valid", 32'(bus_if.out_valid), 32'(q.size() != 0));
        check("count_max", 32'(bus_if.count <= DEPTH), 32'd1);
        if (q.size() != 0) begin
            check("out_data", 32'(bus_if.out_data), 32'(q[0][7:0]));
            check("out_partial", 32'(bus_if.out_partial), 32'(q[0][8]));
        end
    endtask

    // One clock of stimulus; the model applies the same handshake rules.
    task automatic cycle(input logic v, input logic [3:0] d, input logic l, input logic r);
        logic       model_ready;
        logic       do_acc;
        logic       do_pop;
        logic [7:0] w;
        bus_if.in_valid  = v;
        bus_if.in_data   = d;
        bus_if.in_last   = l;
        bus_if.out_ready = r;
        #1;
        model_ready = (q.size() != DEPTH);
        check("in_ready", 32'(bus_if.in_ready), 32'(model_ready));
        do_acc = v && model_ready;
        do_pop = r && (q.size() != 0);
        @(posedge clk);
        #1;
        if (do_pop) void'(q.pop_front());
        if (do_acc) begin
            beats.push_back(d);
            if (l || beats.size() == RATIO) begin
                w = INIT_VAL;
                foreach (beats[k]) w[k*IN_WIDTH +: IN_WIDTH] = beats[k];
                q.push_back({beats.size() < RATIO, w});
                beats.delete();
                n_words++;
            end
        end
        check_outputs();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = 4'h0;
        bus_if.in_last  = 1'b0;
        bus_if.out_ready = 1'b1;
        #1;
        check("rst_in_ready", 32'(bus_if.in_ready), 32'd0);
        @(posedge clk);
        #1;
        q.delete();
        beats.delete();
        check("rst_count", 32'(bus_if.count), 32'd0);
        check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst_out_data", 32'(bus_if.out_data), 32'd0);
        check("rst_out_partial", 32'(bus_if.out_partial), 32'd0);
        check("rst_in_ready_hold", 32'(bus_if.in_ready), 32'd0);
        reset = 1'b0;
        bus_if.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) cycle(1'b0, 4'h0, 1'b0, 1'b1);
        check("drain_done", 32'(q.size()), 32'd0);
    endtask

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = 4'h0;
        bus_if.in_last   = 1'b0;
        bus_if.out_ready = 1'b0;
        @(posedge clk);
        #1;
        apply_reset();

        // Full word
        cycle(1'b1, 4'hA, 1'b0, 1'b1);
        check("t1_no_early_valid", 32'(bus_if.out_valid), 32'd0);
        cycle(1'b1, 4'h5, 1'b0, 1'b1);
        check("t1_data", 32'(bus_if.out_data), 32'h5A);
        check("t1_partial", 32'(bus_if.out_partial), 32'd0);
        cycle(1'b0, 4'h0, 1'b0, 1'b1);
        check("t1_count_zero", 32'(bus_if.count), 32'd0);

        // Early last, then a normal word
        cycle(1'b1, 4'h3, 1'b1, 1'b1);
        check("t2_data", 32'(bus_if.out_data), 32'hF3);
        check("t2_partial", 32'(bus_if.out_partial), 32'd1);
        cycle(1'b1, 4'h1, 1'b0, 1'b1);
        cycle(1'b1, 4'h2, 1'b1, 1'b1);
        check("t2_data2", 32'(bus_if.out_data), 32'h21);
        check("t2_partial2", 32'(bus_if.out_partial), 32'd0);
        drain();

        // Backpressure, then pop at full with a beat waiting
        for (int i = 0; i < 8; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0);
        check("t3_count_full", 32'(bus_if.count), 32'd4);
        check("t3_in_ready_low", 32'(bus_if.in_ready), 32'd0);
        cycle(1'b1, 4'h8, 1'b0, 1'b0);
        check("t3_head", 32'(bus_if.out_data), 32'h10);
        cycle(1'b1, 4'h8, 1'b0, 1'b1);
        check("t4_count_after_pop", 32'(bus_if.count), 32'd3);
        check("t4_in_ready_next", 32'(bus_if.in_ready), 32'd1);
        cycle(1'b1, 4'h8, 1'b0, 1'b0);
        cycle(1'b1, 4'h9, 1'b0, 1'b0);
        check("t4_refill", 32'(bus_if.count), 32'd4);
        drain();

        // Reset mid-word with entries pending
        for (int i = 1; i <= 4; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0);
        cycle(1'b1, 4'h7, 1'b0, 1'b0);
        check("t5_pending", 32'(bus_if.count), 32'd2);
        apply_reset();
        cycle(1'b1, 4'h1, 1'b0, 1'b0);
        cycle(1'b1, 4'h2, 1'b0, 1'b0);
        check("t5_data", 32'(bus_if.out_data), 32'h21);
        check("t5_partial", 32'(bus_if.out_partial), 32'd0);
        drain();

        // Random stream across pointer wrap
        n_words = 0;
        for (int i = 0; i < 2000 && n_words < 10; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)));
        end
        check("t6_words", 32'(n_words >= 10), 32'd1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
